// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// controller states and the default width/iteration count.
package mult_div_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = MD_WIDTH;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Bundle between the execute stage and the multiply/divide unit.
// start is a request honoured only while busy is low; each accepted start yields one done pulse.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  import mult_div_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             write_hi;
  logic             write_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  state_t           state;

  modport master (
    output start, op, operand_a, operand_b, write_hi, write_lo, wdata,
    input  busy, done, hi, lo, state
  );

  modport slave (
    input  start, op, operand_a, operand_b, write_hi, write_lo, wdata,
    output busy, done, hi, lo, state
  );

endinterface

// File: rtl/mult_div_unit_twos_neg.sv
// Conditional two's-complement negate; passes din through when en is low.
module twos_neg #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU on magnitudes with a final sign fix,
// fixed latency of ITER+1 cycles, results held in architectural HI/LO.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(ITER);

  state_t           cur_state;
  state_t           nxt_state;
  op_t              op_q;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_res;
  logic             neg_rem;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             is_signed_in;
  logic             is_div;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic             can_sub;
  logic [WIDTH-1:0] sub_val;

  assign is_signed_in = ~bus.op[0];
  assign is_div       = (op_q == OP_DIV) || (op_q == OP_DIVU);

  twos_neg #(.W(WIDTH)) u_abs_a (
    .en   (is_signed_in & bus.operand_a[WIDTH-1]),
    .din  (bus.operand_a),
    .dout (abs_a)
  );

  twos_neg #(.W(WIDTH)) u_abs_b (
    .en   (is_signed_in & bus.operand_b[WIDTH-1]),
    .din  (bus.operand_b),
    .dout (abs_b)
  );

  twos_neg #(.W(2*WIDTH)) u_fix_prod (
    .en   (neg_res),
    .din  (prod),
    .dout (prod_fix)
  );

  twos_neg #(.W(WIDTH)) u_fix_quo (
    .en   (neg_res),
    .din  (quo),
    .dout (quo_fix)
  );

  twos_neg #(.W(WIDTH)) u_fix_rem (
    .en   (neg_rem),
    .din  (rem),
    .dout (rem_fix)
  );

  // One step of each algorithm. The subtract result always fits WIDTH bits
  // because it is taken only when the shifted remainder is >= divisor.
  always_comb begin
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
    shifted = {rem, quo[WIDTH-1]};
    can_sub = (shifted >= {1'b0, mag_b});
    sub_val = shifted[WIDTH-1:0] - mag_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= ST_IDLE;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE: if (bus.start) nxt_state = ST_CALC;
      ST_CALC: if (cnt == '0) nxt_state = ST_FIX;
      ST_FIX:  nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_MULT;
      mag_a   <= '0;
      mag_b   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (cur_state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q    <= op_t'(bus.op);
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            neg_res <= is_signed_in & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
            neg_rem <= is_signed_in & bus.operand_a[WIDTH-1];
            cnt     <= CW'(ITER - 1);
            prod    <= {{WIDTH{1'b0}}, abs_b};
            rem     <= '0;
            quo     <= abs_a;
          end else begin
            if (bus.write_hi) hi_q <= bus.wdata;
            if (bus.write_lo) lo_q <= bus.wdata;
          end
        end
        ST_CALC: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            rem <= can_sub ? sub_val : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], can_sub};
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end
        end
        ST_FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (cur_state != ST_IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = cur_state;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the processor's execute stage, directly downstream of the register bank. Captures the two register-bank read values (rs, rt) on a start strobe, computes MULT/MULTU/DIV/DIVU over a fixed 33-cycle latency, and holds the 64-bit result in architectural HI/LO registers. The same HI/LO registers serve MFHI/MFLO reads and MTHI/MTLO writes.

## Interface
Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each
- ITER, WIDTH, iteration count; not overridden independently

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  32  rs value from register bank (multiplicand / dividend)
- operand_b  input  32  rt value from register bank (multiplier / divisor)
- write_hi  input  1  MTHI strobe
- write_lo  input  1  MTLO strobe
- wdata  input  32  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, HI/LO just updated by an operation
- hi  output  32  HI register (MULT: upper product; DIV: remainder)
- lo  output  32  LO register (MULT: lower product; DIV: quotient)

## Operation
- Reset (rst_n low, any time): state IDLE, hi=lo=0, busy=0, done=0, counter=0; operation in flight discarded.
- States: IDLE, CALC, FIX.
- IDLE: start=1 captures op, operand magnitudes (signed ops: two's-complement absolute value; unsigned: raw), result signs; -> CALC, counter=ITER-1. start has priority over write_hi/write_lo in the same cycle (writes dropped).
- IDLE, no start: write_hi loads hi<=wdata, write_lo loads lo<=wdata; both may assert together.
- CALC: one iteration per cycle. Multiply: shift-add on 64-bit accumulator. Divide: restoring shift-subtract, 33-bit partial remainder. counter==0 -> FIX.
- FIX: apply signs (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign); write hi/lo; done<=1; -> IDLE.
- start, write_hi, write_lo ignored while busy.
- Divide by zero: no trap; result falls out of the algorithm: quotient magnitude 0xFFFFFFFF, remainder magnitude |a|, then sign fix applied as normal.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0, no flag.
- Operands not required stable after the start cycle.

## Timing
- Start accepted at edge E: busy=1 after E; CALC iterations at edges E+1..E+32; FIX at E+33 updates hi/lo, sets done=1, busy=0.
- done high exactly one cycle (E+33 to E+34); new start accepted in that cycle.
- hi/lo change only at the FIX edge, reset, or MTHI/MTLO edge; hold otherwise, including during CALC.
- MTHI/MTLO: value visible on hi/lo the cycle after the strobe edge.
- Back-to-back: start in done cycle -> next done 33 cycles later.

## Structure
- Package mult_div_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (ST_IDLE, ST_CALC, ST_FIX), ITER constant.
- Sub-module twos_neg: conditional two's-complement negate (width parameter, enable), instanced for operand abs and result sign fix.
- Controller FSM and datapath in mult_div_unit.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 -> done at E+33, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- During CALC: start with new operands and write_hi with 0x12345678 -> both ignored; result of first operation unchanged; busy stays 1 until E+33.
- rst_n low at E+10 of a MULTU -> immediately busy=0, done=0, hi=lo=0; no done pulse afterwards; new start after release completes normally.
- IDLE: write_hi=write_lo=1, wdata=0xCAFEF00D -> hi=lo=0xCAFEF00D next cycle; start+write_lo same cycle -> write dropped, operation runs.
